// File: rtl/mip_pkg.sv
// Shared encodings for the morphological image pipeline sequencer:
// one-hot FSM states, per-pass filter op codes and LED bit positions.
package mip_pkg;

  typedef enum logic [6:0] {
    StIdle   = 7'b000_0001,
    StRom    = 7'b000_0010,
    StFstart = 7'b000_0100,
    StFwait  = 7'b000_1000,
    StRam    = 7'b001_0000,
    StVga    = 7'b010_0000,
    StFault  = 7'b100_0000
  } state_e;

  localparam logic [1:0] OP_BYP = 2'b00;
  localparam logic [1:0] OP_ERO = 2'b01;
  localparam logic [1:0] OP_DIL = 2'b10;

  localparam int unsigned LED_RST = 0;
  localparam int unsigned LED_PLL = 1;
  localparam int unsigned LED_ROM = 2;
  localparam int unsigned LED_ERO = 3;
  localparam int unsigned LED_DIL = 4;
  localparam int unsigned LED_RAM = 5;
  localparam int unsigned LED_VGA = 6;
  localparam int unsigned LED_ERR = 7;

endpackage

// File: rtl/mip_seq_ctrl_if.sv
// Start/done handshake between the sequencer (master) and the active
// morphological filter (slave), including the per-pass op enables.
interface mip_seq_ctrl_if;

  logic filt_start;
  logic filt_done;
  logic erosion_en;
  logic dilation_en;

  modport master (
    output filt_start,
    output erosion_en,
    output dilation_en,
    input  filt_done
  );

  modport slave (
    input  filt_start,
    input  erosion_en,
    input  dilation_en,
    output filt_done
  );

endinterface

// File: rtl/mip_watchdog.sv
// Saturating cycle counter for the filter-wait watchdog; tc flags the last
// allowed cycle while counting is enabled.
module mip_watchdog #(
  parameter int unsigned TMO_W   = 24,
  parameter int unsigned TMO_CYC = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [TMO_W-1:0] TcVal = TMO_W'(TMO_CYC - 1);

  logic [TMO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !tc) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  assign tc = en && (cnt_q == TcVal);

endmodule

// File: rtl/mip_seq_ctrl.sv
// Frame sequencer: ROM read, up to MAX_PASS erosion/dilation/bypass passes,
// RAM write and VGA display, with watchdog fault and PLL-loss recovery.
module mip_seq_ctrl
  import mip_pkg::*;
#(
  parameter int unsigned MAX_PASS = 4,
  parameter int unsigned PASS_W   = 2,
  parameter int unsigned TMO_W    = 24,
  parameter int unsigned TMO_CYC  = 10_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pll_lock,
  input  logic [PASS_W:0]       num_pass,
  input  logic [2*MAX_PASS-1:0] op_cfg,
  input  logic                  restart,
  mip_seq_ctrl_if.master        filt,
  output logic                  rom_flag,
  output logic [PASS_W-1:0]     pass_idx,
  output logic                  ram_flag,
  output logic                  vga_flag,
  output logic                  busy,
  output logic                  err,
  output logic [7:0]            led_status
);

  localparam logic [PASS_W:0] MaxCnt = (PASS_W+1)'(MAX_PASS);
  localparam logic [PASS_W:0] CntOne = (PASS_W+1)'(1);

  state_e                state_q;
  logic [PASS_W:0]       cnt_q;
  logic [2*MAX_PASS-1:0] op_q;
  logic [PASS_W-1:0]     idx_q;
  logic                  filt_start_q, ero_q, dil_q;
  logic                  rom_q, ram_q, vga_q, busy_q, err_q;

  logic [PASS_W:0] num_clamped;
  logic [PASS_W:0] cnt_m1;
  logic [1:0]      op_cur;
  logic            last;
  logic            wd_tc;

  assign num_clamped = (num_pass > MaxCnt) ? MaxCnt : num_pass;
  assign cnt_m1      = cnt_q - CntOne;
  assign last        = ({1'b0, idx_q} == cnt_m1);

  always_comb begin
    op_cur = OP_BYP;
    for (int k = 0; k < MAX_PASS; k++) begin
      if (idx_q == PASS_W'(k)) op_cur = op_q[2*k +: 2];
    end
  end

  mip_watchdog #(
    .TMO_W   (TMO_W),
    .TMO_CYC (TMO_CYC)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (state_q == StFstart),
    .en  (state_q == StFwait),
    .tc  (wd_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      filt_start_q <= 1'b0;
      ero_q        <= 1'b0;
      dil_q        <= 1'b0;
      rom_q        <= 1'b0;
      ram_q        <= 1'b0;
      vga_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else if (!pll_lock && (state_q != StIdle)) begin
      // Losing the PLL abandons the frame from any state.
      state_q      <= StIdle;
      idx_q        <= '0;
      filt_start_q <= 1'b0;
      ero_q        <= 1'b0;
      dil_q        <= 1'b0;
      rom_q        <= 1'b0;
      ram_q        <= 1'b0;
      vga_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      filt_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pll_lock) begin
            state_q <= StRom;
            busy_q  <= 1'b1;
          end
        end
        StRom: begin
          rom_q   <= 1'b1;
          cnt_q   <= num_clamped;
          op_q    <= op_cfg;
          idx_q   <= '0;
          state_q <= StFstart;
        end
        StFstart: begin
          // An empty frame still spends one decode cycle here, which keeps
          // ram_flag at a fixed offset from rom_flag.
          if (cnt_q == '0) begin
            state_q <= StRam;
          end else if ((op_cur == OP_ERO) || (op_cur == OP_DIL)) begin
            filt_start_q <= 1'b1;
            ero_q        <= (op_cur == OP_ERO);
            dil_q        <= (op_cur == OP_DIL);
            state_q      <= StFwait;
          end else if (last) begin
            state_q <= StRam;
          end else begin
            idx_q <= idx_q + PASS_W'(1);
          end
        end
        StFwait: begin
          if (filt.filt_done) begin
            ero_q <= 1'b0;
            dil_q <= 1'b0;
            if (last) begin
              state_q <= StRam;
            end else begin
              idx_q   <= idx_q + PASS_W'(1);
              state_q <= StFstart;
            end
          end else if (wd_tc) begin
            ero_q   <= 1'b0;
            dil_q   <= 1'b0;
            rom_q   <= 1'b0;
            ram_q   <= 1'b0;
            vga_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
            state_q <= StFault;
          end
        end
        StRam: begin
          ram_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StVga;
        end
        StVga: begin
          vga_q <= 1'b1;
          if (restart) begin
            rom_q   <= 1'b0;
            ram_q   <= 1'b0;
            vga_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRom;
          end
        end
        StFault: begin
          if (restart) begin
            err_q   <= 1'b0;
            busy_q  <= pll_lock;
            state_q <= pll_lock ? StRom : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign filt.filt_start  = filt_start_q;
  assign filt.erosion_en  = ero_q;
  assign filt.dilation_en = dil_q;
  assign rom_flag         = rom_q;
  assign pass_idx         = idx_q;
  assign ram_flag         = ram_q;
  assign vga_flag         = vga_q;
  assign busy             = busy_q;
  assign err              = err_q;

  always_comb begin
    led_status          = '0;
    led_status[LED_RST] = rst;
    led_status[LED_PLL] = pll_lock;
    led_status[LED_ROM] = rom_q;
    led_status[LED_ERO] = ero_q;
    led_status[LED_DIL] = dil_q;
    led_status[LED_RAM] = ram_q;
    led_status[LED_VGA] = vga_q;
    led_status[LED_ERR] = err_q;
  end

endmodule

// File: tb/tb_mip_seq_ctrl.sv
// Directed bench for mip_seq_ctrl: latency, multi-pass ops, bypass, watchdog
// fault, shadowed config, PLL loss/relock and asynchronous reset.
module tb_mip_seq_ctrl;

  logic       clk;
  logic       rst;
  logic       pll_lock;
  logic [2:0] num_pass;
  logic [7:0] op_cfg;
  logic       restart;
  logic       rom_flag;
  logic [1:0] pass_idx;
  logic       ram_flag;
  logic       vga_flag;
  logic       busy;
  logic       err;
  logic [7:0] led_status;

  int n_checks = 0;
  int n_fail   = 0;
  int n_start  = 0;
  int base;
  bit auto_done;

  mip_seq_ctrl_if filt ();

  mip_seq_ctrl #(
    .MAX_PASS (4),
    .PASS_W   (2),
    .TMO_W    (8),
    .TMO_CYC  (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pll_lock   (pll_lock),
    .num_pass   (num_pass),
    .op_cfg     (op_cfg),
    .restart    (restart),
    .filt       (filt),
    .rom_flag   (rom_flag),
    .pass_idx   (pass_idx),
    .ram_flag   (ram_flag),
    .vga_flag   (vga_flag),
    .busy       (busy),
    .err        (err),
    .led_status (led_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) if (filt.filt_start === 1'b1) n_start <= n_start + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_vga(input int budget);
    int i;
    for (i = 0; i < budget && vga_flag !== 1'b1; i++) tick();
    check("vga_wait_bound", vga_flag, 1);
  endtask

  // Filter model: answer each filt_start with a done pulse 10 cycles later.
  initial begin
    filt.filt_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (filt.filt_start === 1'b1 && auto_done) begin
        repeat (9) begin
          @(posedge clk);
          #1;
        end
        filt.filt_done = 1'b1;
        @(posedge clk);
        #1;
        filt.filt_done = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; pll_lock = 1'b1; num_pass = 3'd0; op_cfg = 8'h00;
    restart = 1'b0; auto_done = 1'b1;
    #2;
    check("rst_rom", rom_flag, 0);
    check("rst_start", filt.filt_start, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", pass_idx, 0);
    check("rst_led", led_status, 8'h03);
    @(posedge clk);
    #1 rst = 1'b0;

    // Zero passes: rom at 2, ram at 4, vga at 5.
    tick(); check("t1_rom_c1", rom_flag, 0);
    tick(); check("t1_rom_c2", rom_flag, 1); check("t1_busy", busy, 1);
    tick(); check("t1_ram_c3", ram_flag, 0);
    tick(); check("t1_ram_c4", ram_flag, 1);
    tick(); check("t1_vga_c5", vga_flag, 1); check("t1_busy_off", busy, 0);
    check("t1_led", led_status, 8'h66);
    check("t1_starts", n_start, 0);

    // Two passes, erosion then dilation; config changed mid-frame is ignored.
    num_pass = 3'd2; op_cfg = 8'h09; restart = 1'b1;
    tick(); restart = 1'b0; base = n_start;
    check("t2_rom_clr", rom_flag, 0); check("t2_vga_clr", vga_flag, 0);
    tick(); check("t2_rom", rom_flag, 1);
    tick(); check("t2_start0", filt.filt_start, 1);
    check("t2_ero0", filt.erosion_en, 1); check("t2_dil0", filt.dilation_en, 0);
    check("t2_idx0", pass_idx, 0);
    op_cfg = 8'h05; num_pass = 3'd0;
    tick(9); check("t2_ero_hold", filt.erosion_en, 1);
    tick(); check("t2_ero_off", filt.erosion_en, 0); check("t2_idx1", pass_idx, 1);
    tick(); check("t2_start1", filt.filt_start, 1);
    check("t2_dil1", filt.dilation_en, 1); check("t2_ero1", filt.erosion_en, 0);
    tick(10); check("t2_dil_off", filt.dilation_en, 0); check("t2_ram_pre", ram_flag, 0);
    tick(); check("t2_ram", ram_flag, 1);
    tick(); check("t2_vga", vga_flag, 1);
    check("t2_starts", n_start - base, 2);

    // Three passes with a bypass in the middle; restart mid-frame is ignored.
    num_pass = 3'd3; op_cfg = 8'h21; restart = 1'b1;
    tick(); restart = 1'b0; base = n_start;
    tick(); check("t3_rom", rom_flag, 1);
    tick(); check("t3_idx0", pass_idx, 0); check("t3_ero0", filt.erosion_en, 1);
    tick(2); restart = 1'b1;
    tick(); restart = 1'b0;
    check("t3_ign_rom", rom_flag, 1); check("t3_ign_ero", filt.erosion_en, 1);
    tick(7); check("t3_idx1", pass_idx, 1); check("t3_ero_off", filt.erosion_en, 0);
    tick(); check("t3_idx2", pass_idx, 2); check("t3_byp_start", filt.filt_start, 0);
    check("t3_byp_dil", filt.dilation_en, 0);
    tick(); check("t3_start2", filt.filt_start, 1); check("t3_dil2", filt.dilation_en, 1);
    tick(10); check("t3_dil_off", filt.dilation_en, 0);
    tick(2); check("t3_vga", vga_flag, 1);
    check("t3_starts", n_start - base, 2);

    // Watchdog: done withheld, fault after 16 wait cycles.
    num_pass = 3'd1; op_cfg = 8'h01; auto_done = 1'b0; restart = 1'b1;
    tick(); restart = 1'b0;
    tick(2); check("t4_ero", filt.erosion_en, 1);
    tick(15); check("t4_err_pre", err, 0); check("t4_ero_pre", filt.erosion_en, 1);
    tick(); check("t4_err", err, 1); check("t4_ero_off", filt.erosion_en, 0);
    check("t4_rom_off", rom_flag, 0); check("t4_busy", busy, 0);
    check("t4_led", led_status, 8'h82);
    num_pass = 3'd2; op_cfg = 8'h09; auto_done = 1'b1;
    tick(2); check("t4_err_hold", err, 1);
    restart = 1'b1;
    tick(); restart = 1'b0; check("t4_err_clr", err, 0);
    tick(); check("t4_rom_back", rom_flag, 1);

    // PLL loss during pass 1, then relock restarts from pass 0.
    tick(); check("t6_idx0", pass_idx, 0);
    tick(10); check("t6_idx1", pass_idx, 1);
    tick(); check("t6_dil", filt.dilation_en, 1);
    tick(2); pll_lock = 1'b0;
    tick(); check("t6_rom_off", rom_flag, 0); check("t6_dil_off", filt.dilation_en, 0);
    check("t6_idx_clr", pass_idx, 0); check("t6_busy", busy, 0);
    check("t6_led", led_status, 8'h00);
    tick(12); pll_lock = 1'b1; base = n_start;
    tick(); check("t6_rom_c1", rom_flag, 0);
    tick(); check("t6_rom_c2", rom_flag, 1);
    tick(); check("t6_restart_idx", pass_idx, 0); check("t6_restart_ero", filt.erosion_en, 1);
    wait_vga(60);
    check("t6_starts", n_start - base, 2);

    // Asynchronous reset mid-frame takes effect without a clock edge.
    restart = 1'b1;
    tick(); restart = 1'b0;
    tick(3); check("t7_ero_pre", filt.erosion_en, 1);
    #2 rst = 1'b1;
    #1;
    check("t7_rom_async", rom_flag, 0); check("t7_ero_async", filt.erosion_en, 0);
    check("t7_busy_async", busy, 0);
    tick(); rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
